// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared command encoding and width helpers for the program sequencer
package pc_pkg;

    typedef enum logic [2:0] {
        CMD_HOLD,
        CMD_INC,
        CMD_BRANCH,
        CMD_LOAD,
        CMD_CALL,
        CMD_RET
    } pc_cmd_e;

    localparam int DEFAULT_PC_WIDTH     = 8;
    localparam int DEFAULT_OFFSET_WIDTH = 8;
    localparam int DEFAULT_STACK_DEPTH  = 4;

    // Level counter must represent 0..DEPTH inclusive
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Return has highest priority; only one command is issued per cycle
    function automatic pc_cmd_e encode_cmd(
        input logic ret,
        input logic call,
        input logic load,
        input logic branch,
        input logic inc
    );
        if (ret)         return CMD_RET;
        else if (call)   return CMD_CALL;
        else if (load)   return CMD_LOAD;
        else if (branch) return CMD_BRANCH;
        else if (inc)    return CMD_INC;
        else             return CMD_HOLD;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// rtl/pc_return_stack.sv - return-address LIFO; silently ignores push when full and pop when empty
module pc_return_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_PC_WIDTH,
    parameter int DEPTH = DEFAULT_STACK_DEPTH,
    parameter int LW    = level_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    localparam int AW = addr_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Write slot is the current level; top entry sits one below it
    assign wr_idx = level[AW-1:0];
    assign rd_idx = AW'(level - LW'(1));
    assign dout   = mem[rd_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= '0;
        end else if (do_push) begin
            level <= level + LW'(1);
        end else if (do_pop) begin
            level <= level - LW'(1);
        end
    end

    // Contents are don't-care after reset, so the array carries no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - fetch program counter with branch/call/return; PC_STACK_TOP_EN adds stack_top
module program_sequencer
    import pc_pkg::*;
#(
    parameter int                  PC_WIDTH     = DEFAULT_PC_WIDTH,
    parameter int                  OFFSET_WIDTH = DEFAULT_OFFSET_WIDTH,
    parameter int                  STACK_DEPTH  = DEFAULT_STACK_DEPTH,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              stall,
    input  logic                              LoadPC,
    input  logic                              IncPC,
    input  logic                              BranchPC,
    input  logic                              CallPC,
    input  logic                              RetPC,
    input  logic [PC_WIDTH-1:0]               new_count,
    input  logic [OFFSET_WIDTH-1:0]           offset,
    output logic [PC_WIDTH-1:0]               count,
    output logic [level_width(STACK_DEPTH)-1:0] stack_level,
    output logic                              stack_full,
    output logic                              stack_empty,
    output logic                              stack_ovf,
`ifdef PC_STACK_TOP_EN
    output logic [PC_WIDTH-1:0]               stack_top,
`endif
    output logic                              stack_unf
);

    pc_cmd_e               cmd;
    logic [PC_WIDTH-1:0]   next_count;
    logic [PC_WIDTH-1:0]   count_inc;
    logic [PC_WIDTH-1:0]   offset_ext;
    logic [PC_WIDTH-1:0]   stk_dout;
    logic                  stk_push;
    logic                  stk_pop;

    // Stall masks every request so nothing downstream can change
    assign cmd = stall ? CMD_HOLD : encode_cmd(RetPC, CallPC, LoadPC, BranchPC, IncPC);

    assign count_inc  = count + PC_WIDTH'(1);
    assign offset_ext = PC_WIDTH'($signed(offset));

    assign stk_push = (cmd == CMD_CALL) && !stack_full;
    assign stk_pop  = (cmd == CMD_RET) && !stack_empty;

    pc_return_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (count_inc),
        .dout  (stk_dout),
        .level (stack_level),
        .full  (stack_full),
        .empty (stack_empty)
    );

    always_comb begin
        next_count = count;
        case (cmd)
            CMD_INC:    next_count = count_inc;
            CMD_BRANCH: next_count = count + offset_ext;
            CMD_LOAD:   next_count = new_count;
            CMD_CALL:   if (!stack_full)  next_count = new_count;
            CMD_RET:    if (!stack_empty) next_count = stk_dout;
            default:    next_count = count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= RESET_VECTOR;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else begin
            count <= next_count;
            if ((cmd == CMD_CALL) && stack_full) begin
                stack_ovf <= 1'b1;
            end
            if ((cmd == CMD_RET) && stack_empty) begin
                stack_unf <= 1'b1;
            end
        end
    end

`ifdef PC_STACK_TOP_EN
    assign stack_top = stack_empty ? '0 : stk_dout;
`endif

endmodule
